// File: rtl/rs_ap_ctrl_done_continue_pipeline.sv
// rtl/rs_ap_ctrl_done_continue_pipeline.sv - pipelined ap_done/ap_continue/ap_idle relay between kernel and controller
module rs_ap_ctrl_done_continue_pipeline #(
  parameter int BODY_LEVEL   = 10,
  parameter int GRACE_PERIOD = BODY_LEVEL * 2
) (
  input  logic clk,
  input  logic reset,
  input  logic kernel_done,
  input  logic kernel_idle,
  output logic kernel_continue,
  output logic ctrl_done,
  input  logic ctrl_continue,
  output logic ctrl_idle
);

  localparam int GW = (GRACE_PERIOD < 1) ? 1 : $clog2(GRACE_PERIOD + 1);

  localparam logic [1:0] H_IDLE = 2'd0;
  localparam logic [1:0] H_WAIT = 2'd1;
  localparam logic [1:0] H_COOL = 2'd2;

  localparam logic [0:0] T_IDLE = 1'b0;
  localparam logic [0:0] T_PEND = 1'b1;

  logic [BODY_LEVEL-1:0] fwd;
  logic [BODY_LEVEL-1:0] ret;
  logic [BODY_LEVEL-1:0] idle_pipe;
  logic [1:0]            head;
  logic [0:0]            tail;
  logic [GW-1:0]         grace;
  logic                  fwd_in;
  logic                  ret_in;

  // Only H_IDLE admits a new done, so at most one token per kernel is ever in flight.
  assign fwd_in = (head == H_IDLE) && kernel_done;
  assign ret_in = (tail == T_PEND) && ctrl_continue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd       <= '0;
      ret       <= '0;
      idle_pipe <= '1;
    end else begin
      fwd[0]       <= fwd_in;
      ret[0]       <= ret_in;
      idle_pipe[0] <= kernel_idle;
      for (int i = 1; i < BODY_LEVEL; i++) begin
        fwd[i]       <= fwd[i-1];
        ret[i]       <= ret[i-1];
        idle_pipe[i] <= idle_pipe[i-1];
      end
    end
  end

  // H_COOL skips one cycle of kernel_done, which is still high while the kernel sees continue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head            <= H_IDLE;
      kernel_continue <= 1'b0;
      grace           <= '0;
    end else begin
      kernel_continue <= 1'b0;
      if (grace != '0) begin
        grace <= grace - GW'(1);
      end
      case (head)
        H_IDLE: begin
          if (kernel_done) begin
            head <= H_WAIT;
          end
        end
        H_WAIT: begin
          if (ret[BODY_LEVEL-1]) begin
            kernel_continue <= 1'b1;
            grace           <= GW'(GRACE_PERIOD);
            head            <= H_COOL;
          end
        end
        H_COOL: head <= H_IDLE;
        default: head <= H_IDLE;
      endcase
    end
  end

  // An arriving token takes priority over a continue seen in T_IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tail <= T_IDLE;
    end else begin
      case (tail)
        T_IDLE: begin
          if (fwd[BODY_LEVEL-1]) begin
            tail <= T_PEND;
          end
        end
        T_PEND: begin
          if (ctrl_continue) begin
            tail <= T_IDLE;
          end
        end
        default: tail <= T_IDLE;
      endcase
    end
  end

  assign ctrl_done = (tail == T_PEND);
  assign ctrl_idle = idle_pipe[BODY_LEVEL-1] && (head == H_IDLE) && (tail == T_IDLE) && (grace == '0);

endmodule

// File: tb/tb_rs_ap_ctrl_done_continue_pipeline.sv
// tb/tb_rs_ap_ctrl_done_continue_pipeline.sv - scoreboard bench for the done/continue relay
module tb_rs_ap_ctrl_done_continue_pipeline;

  localparam int BL = 10;
  localparam int GP = 2 * BL;

  localparam int EV_DONE_RISE = 0;
  localparam int EV_DONE_FALL = 1;
  localparam int EV_KCONT     = 2;
  localparam int EV_IDLE_RISE = 3;
  localparam int EV_IDLE_FALL = 4;

  logic clk = 1'b0;
  logic reset;
  logic kernel_done;
  logic kernel_idle;
  logic kernel_continue;
  logic ctrl_done;
  logic ctrl_continue;
  logic ctrl_idle;

  int cyc      = 0;
  int tests    = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  bit p_done   = 1'b0;
  bit p_kc     = 1'b0;
  bit p_idle   = 1'b1;

  int q_done_rise[$];
  int q_done_fall[$];
  int q_kcont[$];
  int q_idle_rise[$];
  int q_idle_fall[$];

  string ev_name[5] = '{"ctrl_done_rise", "ctrl_done_fall", "kernel_continue", "ctrl_idle_rise", "ctrl_idle_fall"};

  always #5 clk = ~clk;

  rs_ap_ctrl_done_continue_pipeline #(
    .BODY_LEVEL  (BL),
    .GRACE_PERIOD(GP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .kernel_done    (kernel_done),
    .kernel_idle    (kernel_idle),
    .kernel_continue(kernel_continue),
    .ctrl_done      (ctrl_done),
    .ctrl_continue  (ctrl_continue),
    .ctrl_idle      (ctrl_idle)
  );

  task automatic expect_ev(input int kind, input int at);
    case (kind)
      EV_DONE_RISE: q_done_rise.push_back(at);
      EV_DONE_FALL: q_done_fall.push_back(at);
      EV_KCONT:     q_kcont.push_back(at);
      EV_IDLE_RISE: q_idle_rise.push_back(at);
      default:      q_idle_fall.push_back(at);
    endcase
  endtask

  task automatic got_ev(input int kind);
    int  exp_at;
    bit  have;
    have   = 1'b0;
    exp_at = 0;
    case (kind)
      EV_DONE_RISE: if (q_done_rise.size() > 0) begin exp_at = q_done_rise.pop_front(); have = 1'b1; end
      EV_DONE_FALL: if (q_done_fall.size() > 0) begin exp_at = q_done_fall.pop_front(); have = 1'b1; end
      EV_KCONT:     if (q_kcont.size() > 0)     begin exp_at = q_kcont.pop_front();     have = 1'b1; end
      EV_IDLE_RISE: if (q_idle_rise.size() > 0) begin exp_at = q_idle_rise.pop_front(); have = 1'b1; end
      default:      if (q_idle_fall.size() > 0) begin exp_at = q_idle_fall.pop_front(); have = 1'b1; end
    endcase
    tests++;
    if (!have) begin
      failures++;
      $display("FAIL %s: unexpected event at cycle %0d, none required", ev_name[kind], cyc);
    end else if (exp_at != cyc) begin
      failures++;
      $display("FAIL %s: event at cycle %0d, required cycle %0d", ev_name[kind], cyc, exp_at);
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_empty(input string name, input int left);
    tests++;
    if (left != 0) begin
      failures++;
      $display("FAIL %s: %0d expected events never seen, required 0", name, left);
    end
  endtask

  // Monitor: turn output transitions into events and match them against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ctrl_done === 1'b1 && !p_done) got_ev(EV_DONE_RISE);
      if (ctrl_done === 1'b0 && p_done)  got_ev(EV_DONE_FALL);
      if (kernel_continue === 1'b1)      got_ev(EV_KCONT);
      if (ctrl_idle === 1'b1 && !p_idle) got_ev(EV_IDLE_RISE);
      if (ctrl_idle === 1'b0 && p_idle)  got_ev(EV_IDLE_FALL);
      p_done = (ctrl_done === 1'b1);
      p_kc   = (kernel_continue === 1'b1);
      p_idle = (ctrl_idle !== 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    reset         = 1'b1;
    kernel_done   = 1'b0;
    kernel_idle   = 1'b1;
    ctrl_continue = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl_done", ctrl_done, 1'b0);
    chk("reset_kernel_continue", kernel_continue, 1'b0);
    chk("reset_ctrl_idle", ctrl_idle, 1'b1);
    reset  = 1'b0;
    cyc    = 0;
    mon_en = 1'b1;

    // Basic handshake, well-behaved kernel that drops done after continue.
    run_to(5);
    kernel_done = 1'b1;
    expect_ev(EV_IDLE_FALL, 6);
    expect_ev(EV_DONE_RISE, 16);
    run_to(30);
    ctrl_continue = 1'b1;
    expect_ev(EV_DONE_FALL, 31);
    expect_ev(EV_KCONT, 41);
    expect_ev(EV_IDLE_RISE, 41 + GP);
    run_to(31);
    ctrl_continue = 1'b0;
    run_to(42);
    kernel_done = 1'b0;

    // Stray continue while nothing is pending.
    run_to(72);
    ctrl_continue = 1'b1;
    run_to(73);
    ctrl_continue = 1'b0;
    run_to(78);
    chk("stray_continue_ctrl_done", ctrl_done, 1'b0);

    // kernel_done held through the continue: second done re-enters after H_COOL.
    run_to(80);
    kernel_done = 1'b1;
    expect_ev(EV_IDLE_FALL, 81);
    expect_ev(EV_DONE_RISE, 91);
    run_to(100);
    ctrl_continue = 1'b1;
    expect_ev(EV_DONE_FALL, 101);
    expect_ev(EV_KCONT, 111);
    expect_ev(EV_DONE_RISE, 123);
    run_to(101);
    ctrl_continue = 1'b0;
    run_to(130);
    ctrl_continue = 1'b1;
    expect_ev(EV_DONE_FALL, 131);
    expect_ev(EV_KCONT, 141);
    expect_ev(EV_IDLE_RISE, 141 + GP);
    run_to(131);
    ctrl_continue = 1'b0;
    run_to(142);
    kernel_done = 1'b0;

    // Reset with a token at fwd[2], kernel has dropped done.
    run_to(170);
    kernel_done = 1'b1;
    expect_ev(EV_IDLE_FALL, 171);
    run_to(173);
    reset       = 1'b1;
    kernel_done = 1'b0;
    expect_ev(EV_IDLE_RISE, 173);
    #1;
    chk("midreset_ctrl_done", ctrl_done, 1'b0);
    chk("midreset_kernel_continue", kernel_continue, 1'b0);
    chk("midreset_ctrl_idle", ctrl_idle, 1'b1);
    run_to(175);
    reset = 1'b0;

    // Reset while kernel_done stays high: done is re-issued after release.
    run_to(200);
    kernel_done = 1'b1;
    expect_ev(EV_IDLE_FALL, 201);
    run_to(203);
    reset = 1'b1;
    expect_ev(EV_IDLE_RISE, 203);
    run_to(205);
    reset = 1'b0;
    expect_ev(EV_IDLE_FALL, 206);
    expect_ev(EV_DONE_RISE, 216);
    run_to(220);
    ctrl_continue = 1'b1;
    expect_ev(EV_DONE_FALL, 221);
    expect_ev(EV_KCONT, 231);
    expect_ev(EV_IDLE_RISE, 231 + GP);
    run_to(221);
    ctrl_continue = 1'b0;
    run_to(232);
    kernel_done = 1'b0;

    // One-cycle idle dip travels the idle pipeline.
    run_to(260);
    kernel_idle = 1'b0;
    expect_ev(EV_IDLE_FALL, 270);
    expect_ev(EV_IDLE_RISE, 271);
    run_to(261);
    kernel_idle = 1'b1;

    run_to(290);
    chk_empty("pending_ctrl_done_rise", q_done_rise.size());
    chk_empty("pending_ctrl_done_fall", q_done_fall.size());
    chk_empty("pending_kernel_continue", q_kcont.size());
    chk_empty("pending_ctrl_idle_rise", q_idle_rise.size());
    chk_empty("pending_ctrl_idle_fall", q_idle_fall.size());

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
